jtag_tdr: RTL and testbench
===========================

# jtag_tdr

Parametrised JTAG test data register, the generalised successor to the 1-bit bypass register. It captures a WIDTH-bit parallel word, shifts it LSB-first from TDI to TDO, and on Update-DR transfers the shifted word to a shadow output. An update only happens when exactly WIDTH bits were shifted. A Bypass mode turns the block into a 1-bit bypass register, so one instance can serve both the selected data register and BYPASS. The block sits between the TAP controller (state decodes), the instruction decoder (Select, Bypass) and the core logic (capture/update words).

## Interface
- WIDTH, 32, shift/update register length in bits; must be ≥ 2.
- RESET_VAL, '0, reset value of update_data (WIDTH bits).

- TCK  input  1  JTAG test clock.
- TRST  input  1  reset TRST, asynchronous, active-low.
- TDI  input  1  serial data in.
- CaptureDR  input  1  TAP is in Capture-DR.
- ShiftDR  input  1  TAP is in Shift-DR.
- UpdateDR  input  1  TAP is in Update-DR.
- Select  input  1  current instruction targets this register. When low, all TAP decodes are ignored.
- Bypass  input  1  1 = act as a 1-bit bypass register.
- capture_data  input  WIDTH  parallel word loaded in Capture-DR.
- TDO  output  1  serial data out, retimed on the falling edge of TCK.
- update_data  output  WIDTH  shadow register, written in Update-DR.
- update_valid  output  1  one-TCK-period pulse marking a successful update.
- len_err  output  1  sticky flag: the last Update-DR saw a shift count ≠ WIDTH.

## Operation
- Internal state:
  - sr[WIDTH-1:0], the shift register.
  - bp, the 1-bit bypass stage.
  - cnt, the shift counter, $clog2(WIDTH+2) bits, saturating at WIDTH+1.
  - tdo_q, the TDO retiming flop.
- Rising edge of TCK, only when Select=1. Priority order is CaptureDR > ShiftDR > hold:
  - Capture, Bypass=0: sr ← capture_data; cnt ← 0.
  - Capture, Bypass=1: bp ← 0; cnt ← 0.
  - Shift, Bypass=0: sr ← {TDI, sr[WIDTH-1:1]}; cnt ← min(cnt+1, WIDTH+1).
  - Shift, Bypass=1: bp ← TDI; cnt is unchanged.
  - Otherwise, or when Select=0: sr, bp and cnt hold.
- Falling edge of TCK:
  - tdo_q ← Bypass ? bp : sr[0].
  - TDO = tdo_q.
- Falling edge of TCK, update path (Select=1, UpdateDR=1, Bypass=0):
  - cnt == WIDTH: update_data ← sr; update_valid ← 1; len_err ← 0.
  - cnt ≠ WIDTH: update_data holds; update_valid ← 0; len_err ← 1.
- update_valid is cleared at every other falling edge, so it is high for exactly one TCK period.
- len_err persists until the next Update-DR evaluation or reset.
- With Bypass=1, Update-DR has no effect on update_data, update_valid or len_err.
- Simultaneous CaptureDR and ShiftDR: capture wins. This is a protocol violation, but the behaviour is defined.

## Timing
- Reset (TRST=0), asynchronous and dominant over both clock edges:
  - sr=0, bp=0, cnt=0, tdo_q=0, so TDO=0.
  - update_data=RESET_VAL, update_valid=0, len_err=0.
- TRST release takes effect on the next TCK edge.
- Serial latency:
  - A bit sampled from TDI on rising edge n reaches sr[0] after WIDTH shift edges.
  - In bypass it appears on TDO at the falling edge following rising edge n, i.e. a one-TCK delay.
- After Capture, TDO shows capture_data[0] from the next falling edge.
- update_data changes only on a falling edge during Update-DR. It is stable from that falling edge until the next successful update.
- The cnt saturation at WIDTH+1 guarantees that over-length shifts (> WIDTH) are flagged as errors and never alias to WIDTH.
- Reset in the middle of a shift aborts the shift. The next Update-DR without a fresh Capture sees cnt=0, so it sets len_err and leaves update_data unchanged.

## Test plan (WIDTH=8, RESET_VAL=8'h5A)
- Reset check:
  - Stimulus: assert TRST=0 asynchronously between edges.
  - Required response: TDO=0, update_data=8'h5A, update_valid=0, len_err=0 immediately.
- Normal Capture/Shift/Update with Select=1, Bypass=0:
  - Stimulus: Capture with capture_data=8'hA5, then 8 shifts with TDI = 8'h3C LSB-first, then Update.
  - Required response: TDO at successive falling edges is 1,0,1,0,0,1,0,1; update_data=8'h3C; update_valid high for one TCK; len_err=0.
- Length error:
  - Stimulus: Capture, then 5 shifts, then Update. Repeat with 9 shifts.
  - Required response: update_data stays 8'h5A, len_err=1, update_valid stays 0. A following correct 8-shift sequence clears len_err and updates.
- Bypass mode:
  - Stimulus: Bypass=1, Capture, then shift TDI=1,1,0, then Update.
  - Required response: TDO = 0,1,1,0 across the falling edges; update_data, update_valid and len_err are unchanged.
- Select gating and priority:
  - Stimulus: Select=0 during 3 shift cycles. Separately, CaptureDR=ShiftDR=1 with capture_data=8'hFF.
  - Required response: with Select=0, sr and TDO hold. In the simultaneous case, sr=8'hFF and cnt=0.
- Reset mid-shift:
  - Stimulus: pulse TRST low after 3 of 8 shifts, then Update.
  - Required response: all outputs return to their reset values; the Update gives len_err=1 and update_data=8'h5A.

Source files
------------

// File: rtl/jtag_tdr.sv
// jtag_tdr: parametrised JTAG test data register with a shadow update stage and
// a 1-bit bypass mode, so one instance serves both a data register and BYPASS.
// Ports: TCK/TRST (async active-low) clock and reset; TDI/TDO serial path;
//   CaptureDR/ShiftDR/UpdateDR TAP decodes; Select/Bypass from the instruction decoder;
//   capture_data in, update_data/update_valid/len_err out to the core.
// Shift state moves on rising TCK; TDO and the update path move on falling TCK.
module jtag_tdr #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             TCK,
  input  logic             TRST,
  input  logic             TDI,
  input  logic             CaptureDR,
  input  logic             ShiftDR,
  input  logic             UpdateDR,
  input  logic             Select,
  input  logic             Bypass,
  input  logic [WIDTH-1:0] capture_data,
  output logic             TDO,
  output logic [WIDTH-1:0] update_data,
  output logic             update_valid,
  output logic             len_err
);

  localparam int                CNT_W    = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WIDTH);
  // Saturating one past WIDTH keeps over-length shifts from wrapping back to WIDTH.
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(WIDTH + 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic             bp_q, bp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             tdo_q, tdo_d;
  logic [WIDTH-1:0] update_data_q, update_data_d;
  logic             update_valid_q, update_valid_d;
  logic             len_err_q, len_err_d;

  // Rising-edge capture/shift; capture wins if both decodes are asserted.
  always_comb begin
    sr_d  = sr_q;
    bp_d  = bp_q;
    cnt_d = cnt_q;
    if (Select) begin
      if (CaptureDR) begin
        cnt_d = '0;
        if (Bypass) bp_d = 1'b0;
        else        sr_d = capture_data;
      end else if (ShiftDR) begin
        if (Bypass) begin
          bp_d = TDI;
        end else begin
          sr_d = {TDI, sr_q[WIDTH-1:1]};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      sr_q  <= '0;
      bp_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      bp_q  <= bp_d;
      cnt_q <= cnt_d;
    end
  end

  // Falling-edge TDO retiming and update. update_valid defaults low so it
  // lasts exactly one TCK period; len_err only changes on an evaluated update.
  always_comb begin
    tdo_d          = Bypass ? bp_q : sr_q[0];
    update_data_d  = update_data_q;
    update_valid_d = 1'b0;
    len_err_d      = len_err_q;
    if (Select && UpdateDR && !Bypass) begin
      if (cnt_q == CNT_FULL) begin
        update_data_d  = sr_q;
        update_valid_d = 1'b1;
        len_err_d      = 1'b0;
      end else begin
        len_err_d      = 1'b1;
      end
    end
  end

  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      tdo_q          <= 1'b0;
      update_data_q  <= RESET_VAL;
      update_valid_q <= 1'b0;
      len_err_q      <= 1'b0;
    end else begin
      tdo_q          <= tdo_d;
      update_data_q  <= update_data_d;
      update_valid_q <= update_valid_d;
      len_err_q      <= len_err_d;
    end
  end

  assign TDO          = tdo_q;
  assign update_data  = update_data_q;
  assign update_valid = update_valid_q;
  assign len_err      = len_err_q;

endmodule

// File: tb/tb_jtag_tdr.sv
// tb_jtag_tdr: directed bench for jtag_tdr at WIDTH=8, RESET_VAL=8'h5A.
// Expected values are queued as stimulus is driven and checked after each TCK cycle.
// Outputs are sampled 1 time unit after the falling edge.
module tb_jtag_tdr;

  logic       TCK = 1'b0;
  logic       TRST;
  logic       TDI;
  logic       CaptureDR;
  logic       ShiftDR;
  logic       UpdateDR;
  logic       Select;
  logic       Bypass;
  logic [7:0] capture_data;
  logic       TDO;
  logic [7:0] update_data;
  logic       update_valid;
  logic       len_err;

  jtag_tdr #(.WIDTH(8), .RESET_VAL(8'h5A)) dut (
    .TCK          (TCK),
    .TRST         (TRST),
    .TDI          (TDI),
    .CaptureDR    (CaptureDR),
    .ShiftDR      (ShiftDR),
    .UpdateDR     (UpdateDR),
    .Select       (Select),
    .Bypass       (Bypass),
    .capture_data (capture_data),
    .TDO          (TDO),
    .update_data  (update_data),
    .update_valid (update_valid),
    .len_err      (len_err)
  );

  always #5 TCK = ~TCK;

  typedef enum int {K_TDO, K_UD, K_UV, K_LE} kind_e;
  typedef struct {
    kind_e      kind;
    logic [7:0] val;
    string      tag;
  } exp_t;

  exp_t       sbq[$];
  int         n_chk  = 0;
  int         n_pass = 0;
  logic [7:0] m_sr;

  task automatic push(input kind_e k, input logic [7:0] v, input string tag);
    exp_t e;
    e.kind = k;
    e.val  = v;
    e.tag  = tag;
    sbq.push_back(e);
  endtask

  task automatic check_all();
    exp_t       e;
    logic [7:0] obs;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.kind)
        K_TDO:   obs = {7'b0, TDO};
        K_UD:    obs = update_data;
        K_UV:    obs = {7'b0, update_valid};
        default: obs = {7'b0, len_err};
      endcase
      n_chk++;
      assert (obs === e.val) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
    end
  endtask

  // One TCK cycle; returns 1 time unit after the falling edge.
  task automatic step(input logic cap, input logic sh, input logic upd, input logic tdi);
    CaptureDR = cap;
    ShiftDR   = sh;
    UpdateDR  = upd;
    TDI       = tdi;
    @(posedge TCK);
    @(negedge TCK);
    #1;
  endtask

  task automatic push_reset_vals(input string tag);
    push(K_TDO, 8'h00, {tag, "_tdo"});
    push(K_UD,  8'h5A, {tag, "_ud"});
    push(K_UV,  8'h00, {tag, "_uv"});
    push(K_LE,  8'h00, {tag, "_le"});
  endtask

  task automatic do_capture(input logic [7:0] w, input logic also_shift, input string tag);
    capture_data = w;
    m_sr = w;
    push(K_TDO, {7'b0, m_sr[0]}, {tag, "_cap_tdo"});
    step(1'b1, also_shift, 1'b0, 1'b0);
    check_all();
  endtask

  task automatic do_shifts(input logic [7:0] w, input int first, input int n, input string tag);
    logic [7:0] wv;
    logic       b;
    wv = w;
    for (int i = 0; i < n; i++) begin
      b = wv[(first + i) % 8];
      m_sr = {b, m_sr[7:1]};
      push(K_TDO, {7'b0, m_sr[0]}, {tag, "_shift_tdo"});
      step(1'b0, 1'b1, 1'b0, b);
      check_all();
    end
  endtask

  task automatic do_update(input logic [7:0] ud, input logic uv, input logic le, input string tag);
    push(K_UD, ud,        {tag, "_upd_ud"});
    push(K_UV, {7'b0, uv}, {tag, "_upd_uv"});
    push(K_LE, {7'b0, le}, {tag, "_upd_le"});
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_all();
    // One idle cycle later: valid must have dropped, data and flag must hold.
    push(K_UD, ud,        {tag, "_idle_ud"});
    push(K_UV, 8'h00,     {tag, "_idle_uv"});
    push(K_LE, {7'b0, le}, {tag, "_idle_le"});
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_all();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    TRST = 1'b1;
    TDI = 1'b0;
    CaptureDR = 1'b0;
    ShiftDR = 1'b0;
    UpdateDR = 1'b0;
    Select = 1'b1;
    Bypass = 1'b0;
    capture_data = 8'h00;
    m_sr = 8'h00;

    // Asynchronous reset between edges, checked before any clock edge.
    #3 TRST = 1'b0;
    #1;
    push_reset_vals("reset");
    check_all();
    @(negedge TCK);
    #1 TRST = 1'b1;

    // Short shift: 5 bits.
    do_capture(8'hA5, 1'b0, "len5");
    do_shifts(8'h3C, 0, 5, "len5");
    do_update(8'h5A, 1'b0, 1'b1, "len5");

    // Over-length shift: 9 bits must not alias to 8.
    do_capture(8'hA5, 1'b0, "len9");
    do_shifts(8'h3C, 0, 9, "len9");
    do_update(8'h5A, 1'b0, 1'b1, "len9");

    // Correct 8-bit transaction: TDO walks A5 LSB-first, update loads 3C, clears len_err.
    do_capture(8'hA5, 1'b0, "norm");
    do_shifts(8'h3C, 0, 8, "norm");
    do_update(8'h3C, 1'b1, 1'b0, "norm");

    // Bypass: TDO = 0,1,1,0; update path untouched.
    Bypass = 1'b1;
    capture_data = 8'hFF;
    push(K_TDO, 8'h00, "byp_cap_tdo");
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_all();
    push(K_TDO, 8'h01, "byp_tdo1");
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check_all();
    push(K_TDO, 8'h01, "byp_tdo2");
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check_all();
    push(K_TDO, 8'h00, "byp_tdo3");
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_all();
    push(K_UD, 8'h3C, "byp_upd_ud");
    push(K_UV, 8'h00, "byp_upd_uv");
    push(K_LE, 8'h00, "byp_upd_le");
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_all();
    Bypass = 1'b0;

    // Select gating: shifts and an update with Select=0 are ignored.
    do_capture(8'hA5, 1'b0, "sel");
    do_shifts(8'hC3, 0, 1, "sel");
    Select = 1'b0;
    for (int k = 0; k < 3; k++) begin
      push(K_TDO, {7'b0, m_sr[0]}, "sel_hold_tdo");
      step(1'b0, 1'b1, 1'b0, 1'b1);
      check_all();
    end
    push(K_UD, 8'h3C, "sel_upd_ud");
    push(K_LE, 8'h00, "sel_upd_le");
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_all();
    Select = 1'b1;
    do_shifts(8'hC3, 1, 7, "sel");
    do_update(8'hC3, 1'b1, 1'b0, "sel");

    // Capture and shift together: capture wins, count restarts at 0.
    do_capture(8'hFF, 1'b1, "prio");
    do_shifts(8'h96, 0, 8, "prio");
    do_update(8'h96, 1'b1, 1'b0, "prio");

    // Reset after 3 of 8 shifts, then Update without a new Capture.
    do_capture(8'hA5, 1'b0, "mid");
    do_shifts(8'h0F, 0, 3, "mid");
    #2 TRST = 1'b0;
    #1;
    push_reset_vals("mid_rst");
    check_all();
    #1 TRST = 1'b1;
    // Re-align to 1 time unit after a falling edge before the next step.
    @(negedge TCK);
    #1;
    do_update(8'h5A, 1'b0, 1'b1, "mid");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
